// File: rtl/textvga_pkg.sv
// Shared timing defaults and address types for the 640x480 text-mode renderer.
package textvga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned H_FP     = 16;
    localparam int unsigned H_SYNC   = 96;
    localparam int unsigned H_BP     = 48;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned V_FP     = 10;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 33;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam int unsigned COLS   = 80;
    localparam int unsigned ROWS   = 30;
    localparam int unsigned FONT_H = 16;

    typedef logic [11:0] vram_addr_t;
    typedef logic [11:0] font_addr_t;

endpackage

// File: rtl/textvram_render_timing.sv
// Raster counters for the text renderer: h/v position, raw sync/enable, cell and scanline indices.
module text_timing #(
    parameter int unsigned H_ACTIVE = textvga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = textvga_pkg::H_FP,
    parameter int unsigned H_SYNC   = textvga_pkg::H_SYNC,
    parameter int unsigned H_BP     = textvga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = textvga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = textvga_pkg::V_FP,
    parameter int unsigned V_SYNC   = textvga_pkg::V_SYNC,
    parameter int unsigned V_BP     = textvga_pkg::V_BP
) (
    input  logic       clk,
    input  logic       rst,
    output logic       active,
    output logic       hsync_raw,
    output logic       vsync_raw,
    output logic       line_end,
    output logic       frame_end,
    output logic [2:0] pix_phase,
    output logic [6:0] col,
    output logic [3:0] scanline,
    output logic [5:0] row_idx
);
    import textvga_pkg::*;

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    always_comb begin
        line_end  = (h_q == H_LAST);
        frame_end = line_end && (v_q == V_LAST);
        h_d = line_end ? '0 : h_q + 10'd1;
        v_d = v_q;
        if (line_end) begin
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
        active    = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
        hsync_raw = !((h_q >= HS_START) && (h_q < HS_END));
        vsync_raw = !((v_q >= VS_START) && (v_q < VS_END));
        pix_phase = h_q[2:0];
        col       = h_q[9:3];
        scanline  = v_q[3:0];
        row_idx   = v_q[9:4];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

endmodule

// File: rtl/textvram_render.sv
// Text-mode renderer: VRAM/font fetch pipeline, 1bpp serialiser and 3-stage sync delay.
// Optional blinking block cursor on scanlines 14..15 when TEXTVRAM_CURSOR_EN is defined.
module textvram_render #(
    parameter int unsigned H_ACTIVE = textvga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = textvga_pkg::H_FP,
    parameter int unsigned H_SYNC   = textvga_pkg::H_SYNC,
    parameter int unsigned H_BP     = textvga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = textvga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = textvga_pkg::V_FP,
    parameter int unsigned V_SYNC   = textvga_pkg::V_SYNC,
    parameter int unsigned V_BP     = textvga_pkg::V_BP,
    parameter int unsigned COLS     = textvga_pkg::COLS,
    parameter int unsigned ROWS     = textvga_pkg::ROWS
) (
    input  logic        clk,
    input  logic        rst,
    output logic [11:0] vram_addr,
    input  logic [7:0]  vram_data,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [11:0] cursor_addr,
    output logic        pix,
    output logic        de,
    output logic        hsync,
    output logic        vsync
);
    import textvga_pkg::*;

    logic       active, hsync_raw, vsync_raw, line_end, frame_end;
    logic [2:0] pix_phase;
    logic [6:0] col;
    logic [3:0] scanline;
    logic [5:0] row_idx;

    text_timing #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk       (clk),
        .rst       (rst),
        .active    (active),
        .hsync_raw (hsync_raw),
        .vsync_raw (vsync_raw),
        .line_end  (line_end),
        .frame_end (frame_end),
        .pix_phase (pix_phase),
        .col       (col),
        .scanline  (scanline),
        .row_idx   (row_idx)
    );

    vram_addr_t row_base_q, row_base_d;
    vram_addr_t vram_addr_q, vram_addr_d;
    font_addr_t font_addr_q, font_addr_d;
    logic [7:0] shreg_q, shreg_d;
    logic [7:0] font_byte;
    logic [5:0] frame_cnt_q, frame_cnt_d;
    logic [2:0] de_q, de_d, hs_q, hs_d, vs_q, vs_d;

`ifdef TEXTVRAM_CURSOR_EN
    logic cursor_hit;
    // vram_addr_q still holds row_base+col of the cell being loaded at phase 2
    always_comb begin
        cursor_hit = (vram_addr_q == cursor_addr) && (scanline[3:1] == 3'b111) && !frame_cnt_q[5];
        font_byte  = cursor_hit ? ~font_data : font_data;
    end
`else
    logic unused_cursor;
    always_comb begin
        unused_cursor = ^cursor_addr;
        font_byte     = font_data;
    end
`endif

    always_comb begin
        row_base_d = row_base_q;
        if (frame_end) begin
            row_base_d = '0;
        end else if (line_end && (scanline == 4'(FONT_H - 1)) && (32'(row_idx) < ROWS - 1)) begin
            row_base_d = row_base_q + 12'(COLS);
        end

        vram_addr_d = vram_addr_q;
        if (active && (pix_phase == 3'd0)) begin
            vram_addr_d = row_base_q + {5'b0, col};
        end

        font_addr_d = font_addr_q;
        if (active && (pix_phase == 3'd1)) begin
            font_addr_d = {vram_data, scanline};
        end

        shreg_d = {shreg_q[6:0], 1'b0};
        if (active && (pix_phase == 3'd2)) begin
            shreg_d = font_byte;
        end

        frame_cnt_d = frame_end ? frame_cnt_q + 6'd1 : frame_cnt_q;

        de_d = {de_q[1:0], active};
        hs_d = {hs_q[1:0], hsync_raw};
        vs_d = {vs_q[1:0], vsync_raw};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_base_q  <= '0;
            vram_addr_q <= '0;
            font_addr_q <= '0;
            shreg_q     <= '0;
            frame_cnt_q <= '0;
            de_q        <= '0;
            hs_q        <= '1;
            vs_q        <= '1;
        end else begin
            row_base_q  <= row_base_d;
            vram_addr_q <= vram_addr_d;
            font_addr_q <= font_addr_d;
            shreg_q     <= shreg_d;
            frame_cnt_q <= frame_cnt_d;
            de_q        <= de_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    always_comb begin
        vram_addr = vram_addr_q;
        font_addr = font_addr_q;
        pix       = shreg_q[7] & de_q[2];
        de        = de_q[2];
        hsync     = hs_q[2];
        vsync     = vs_q[2];
    end

endmodule
